axi_split_xform_n: RTL and testbench
====================================

Name: axi_split_xform_n

Overview:
- N-way AXI-Stream broadcast splitter with a per-output transform (pass-through or bitwise invert) and per-output buffering.
- Runtime enable and invert masks are latched on packet boundaries, so a packet is never split across configurations.
- Sits between a block's input stream and several parallel processing paths of different latency. It is the generalised successor of the fixed two-way pass/invert splitter.

Parameters:
- WIDTH, 32: data width in bits.
- NUM_OUTPUTS, 4: number of output ports, 1..16.
- FIFO_SIZE, 2: log2 of per-output FIFO depth; depth = 2^FIFO_SIZE entries, minimum 1 (2 entries).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- clear  in  1  synchronous flush; same effect as reset on state and FIFOs
- enable_mask  in  NUM_OUTPUTS  bit k=1 routes packets to output k
- invert_mask  in  NUM_OUTPUTS  bit k=1 outputs ~tdata on output k
- i_tdata  in  WIDTH  input data
- i_tlast  in  1  input end of packet
- i_tvalid  in  1  input valid
- i_tready  out  1  input ready
- o_tdata  out  NUM_OUTPUTS*WIDTH  output k occupies bits [k*WIDTH +: WIDTH]
- o_tlast  out  NUM_OUTPUTS  per-output last
- o_tvalid  out  NUM_OUTPUTS  per-output valid
- o_tready  in  NUM_OUTPUTS  per-output ready
- fifo_occupied  out  NUM_OUTPUTS*(FIFO_SIZE+1)  per-output entry count, for status readback

Behaviour:
- Reset/clear
  - Clock and reset are clk and reset; reset is synchronous and active-high.
  - On reset or clear: all FIFOs empty, o_tvalid=0, fifo_occupied=0, packet state IDLE, latched masks=0.
  - i_tready is combinational and valid in the cycle after reset deasserts.
  - Reset or clear asserted mid-packet discards the partial packet. The next accepted beat is treated as a packet start.
- Packet state machine
  - IDLE: the first accepted beat (i_tvalid & i_tready) is a packet start. enable_mask and invert_mask are captured into act_en/act_inv in that cycle and also govern that beat.
  - If the start beat has i_tlast=1, stay IDLE. Otherwise go to IN_PKT.
  - IN_PKT: use the latched act_en/act_inv. Mask input changes are ignored. Return to IDLE on the accepted beat with i_tlast=1.
- Handshake
  - Let eff_en = enable_mask in IDLE, act_en in IN_PKT.
  - i_tready = AND over k of (!eff_en[k] | !full[k]).
  - A beat is written to every FIFO k with eff_en[k], all in the same cycle (lockstep broadcast).
  - eff_en == 0: i_tready=1 and beats are consumed and dropped; the state machine still tracks tlast.
  - Fullness is evaluated before the same-cycle pop. A full FIFO blocks input even when its output is popping that cycle (no write-through).
- Transform
  - The stored word is {i_tlast, eff_inv[k] ? ~i_tdata : i_tdata}. The transform is applied at write; tlast is never inverted.
- Output
  - Each FIFO is a standard AXI FIFO: o_tvalid[k] = !empty[k]; pop on o_tvalid[k] & o_tready[k].
  - Latency is 1 cycle: a beat accepted at edge n is visible on o_tvalid at edge n+1.
  - A FIFO disabled for the current packet keeps draining previously buffered beats.
  - Outputs are mutually independent. A stalled enabled output eventually back-pressures the input only when its FIFO is full.
- Occupancy
  - fifo_occupied[k] is incremented on push-only, decremented on pop-only, and unchanged on simultaneous push and pop.
  - Range is 0..2^FIFO_SIZE; full when count == 2^FIFO_SIZE.
  - Pointers wrap modulo 2^FIFO_SIZE.
- No data reordering, duplication or loss on enabled outputs.

Decomposition:
- Shared package holds:
  - the state encoding localparams ST_IDLE and ST_IN_PKT;
  - the packed-entry width constant ENTRY_W = WIDTH+1;
  - the index helper for the flattened o_tdata bus.
- One sub-module, split_xform_fifo: a single-output FIFO with push, pop, full, empty and occupancy, parameterised by ENTRY_W and FIFO_SIZE.
- The top level instantiates split_xform_fifo NUM_OUTPUTS times in a generate loop. It also holds the state machine, the mask latches and the transform muxes.

Test Plan:
- Broadcast with transform:
  - Setup: NUM_OUTPUTS=4, enable=4'b1111, invert=4'b1010, all o_tready=1.
  - Stimulus: 4-beat packet 0x00000001..0x00000004.
  - Required: outputs 0 and 2 carry 0x1..0x4; outputs 1 and 3 carry 0xFFFFFFFE..0xFFFFFFFB; tlast only on beat 4; each beat appears 1 cycle after acceptance.
- Mid-packet mask change:
  - Stimulus: start a packet with enable=4'b0011 and change it to 4'b1100 at beat 2 of 5.
  - Required: all 5 beats appear on outputs 0 and 1, none on outputs 2 and 3. The next packet goes to outputs 2 and 3 only.
- Back-pressure:
  - Setup: FIFO_SIZE=2; o_tready[1]=0, all others 1.
  - Stimulus: stream 10 beats.
  - Required: i_tready drops after 4 accepted beats; fifo_occupied[1]=4 while outputs 0, 2 and 3 have drained. Raising o_tready[1] resumes flow with no beat lost or duplicated.
- All outputs disabled:
  - Stimulus: enable=0, send a 3-beat packet.
  - Required: i_tready=1 throughout, all o_tvalid stay 0, and the state returns to IDLE after tlast.
- Single-beat packets and full/empty edge:
  - Stimulus: back-to-back single-beat packets, each with a new mask, plus a simultaneous push and pop at full.
  - Required: the mask is applied per beat; at full, a simultaneous pop does not admit a push and the count stays at 4.
- Reset and clear mid-packet:
  - Stimulus: assert clear for 1 cycle after beat 2 of 4, then send a new 2-beat packet.
  - Required: all o_tvalid=0 and fifo_occupied=0 in the cycle after clear; the 2-beat packet is routed with newly latched masks. Repeat with reset and require the same result.

Source files
------------

// File: rtl/axi_split_xform_n_pkg.sv
// axi_split_xform_n_pkg: packet state encoding, FIFO entry width and output lane indexing
package axi_split_xform_n_pkg;
    typedef enum logic {ST_IDLE = 1'b0, ST_IN_PKT = 1'b1} pkt_state_e;
    localparam int DEF_WIDTH = 32;
    localparam int ENTRY_W = DEF_WIDTH + 1;
    function automatic int entry_width(input int w);
        return w + 1;
    endfunction
    function automatic int lane_lsb(input int k, input int w);
        return k * w;
    endfunction
endpackage

// File: rtl/axi_split_xform_n_fifo.sv
// split_xform_fifo: single-output FIFO with push/pop, full/empty flags and entry count
module split_xform_fifo #(
    parameter int ENTRY_W   = 33,
    parameter int FIFO_SIZE = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 i_push,
    input  logic [ENTRY_W-1:0]   i_data,
    input  logic                 i_pop,
    output logic [ENTRY_W-1:0]   o_data,
    output logic                 o_full,
    output logic                 o_empty,
    output logic [FIFO_SIZE:0]   o_count
);
    localparam int DEPTH = 1 << FIFO_SIZE;
    logic [ENTRY_W-1:0]   r_mem [DEPTH];
    logic [FIFO_SIZE-1:0] r_wr_ptr;
    logic [FIFO_SIZE-1:0] r_rd_ptr;
    logic [FIFO_SIZE:0]   r_count;
    logic                 w_push;
    logic                 w_pop;
    assign o_full  = r_count == (FIFO_SIZE + 1)'(DEPTH);
    assign o_empty = r_count == '0;
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    always_ff @(posedge clk) begin
        if (reset | clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push != w_pop) r_count <= w_push ? r_count + 1'b1 : r_count - 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end
endmodule

// File: rtl/axi_split_xform_n.sv
// axi_split_xform_n: N-way AXI-Stream broadcast with per-output invert and buffering, masks latched per packet
module axi_split_xform_n
    import axi_split_xform_n_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int NUM_OUTPUTS = 4,
    parameter int FIFO_SIZE   = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               clear,
    input  logic [NUM_OUTPUTS-1:0]             enable_mask,
    input  logic [NUM_OUTPUTS-1:0]             invert_mask,
    input  logic [WIDTH-1:0]                   i_tdata,
    input  logic                               i_tlast,
    input  logic                               i_tvalid,
    output logic                               i_tready,
    output logic [NUM_OUTPUTS*WIDTH-1:0]       o_tdata,
    output logic [NUM_OUTPUTS-1:0]             o_tlast,
    output logic [NUM_OUTPUTS-1:0]             o_tvalid,
    input  logic [NUM_OUTPUTS-1:0]             o_tready,
    output logic [NUM_OUTPUTS*(FIFO_SIZE+1)-1:0] fifo_occupied
);
    localparam int EW = entry_width(WIDTH);
    localparam int CW = FIFO_SIZE + 1;
    pkt_state_e             r_state;
    pkt_state_e             w_state_nxt;
    logic [NUM_OUTPUTS-1:0] r_act_en;
    logic [NUM_OUTPUTS-1:0] r_act_inv;
    logic [NUM_OUTPUTS-1:0] w_eff_en;
    logic [NUM_OUTPUTS-1:0] w_eff_inv;
    logic [NUM_OUTPUTS-1:0] w_full;
    logic [NUM_OUTPUTS-1:0] w_empty;
    logic                   w_acc;
    // A packet start beat is governed by the live masks; the rest of the packet by the latched copy
    assign w_eff_en  = (r_state == ST_IDLE) ? enable_mask : r_act_en;
    assign w_eff_inv = (r_state == ST_IDLE) ? invert_mask : r_act_inv;
    assign i_tready  = &(~w_eff_en | ~w_full);
    assign w_acc     = i_tvalid & i_tready;
    always_comb begin
        w_state_nxt = r_state;
        if (w_acc) w_state_nxt = i_tlast ? ST_IDLE : ST_IN_PKT;
    end
    always_ff @(posedge clk) begin
        if (reset | clear) begin
            r_state   <= ST_IDLE;
            r_act_en  <= '0;
            r_act_inv <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_acc && r_state == ST_IDLE) begin
                r_act_en  <= enable_mask;
                r_act_inv <= invert_mask;
            end
        end
    end
    for (genvar k = 0; k < NUM_OUTPUTS; k++) begin : g_lane
        logic [EW-1:0] w_wr_data;
        logic [EW-1:0] w_rd_data;
        assign w_wr_data = {i_tlast, w_eff_inv[k] ? ~i_tdata : i_tdata};
        split_xform_fifo #(
            .ENTRY_W  (EW),
            .FIFO_SIZE(FIFO_SIZE)
        ) u_fifo (
            .clk    (clk),
            .reset  (reset),
            .clear  (clear),
            .i_push (w_acc & w_eff_en[k]),
            .i_data (w_wr_data),
            .i_pop  (o_tvalid[k] & o_tready[k]),
            .o_data (w_rd_data),
            .o_full (w_full[k]),
            .o_empty(w_empty[k]),
            .o_count(fifo_occupied[k*CW +: CW])
        );
        assign o_tvalid[k]                          = ~w_empty[k];
        assign o_tlast[k]                           = w_rd_data[WIDTH];
        assign o_tdata[lane_lsb(k, WIDTH) +: WIDTH] = w_rd_data[WIDTH-1:0];
    end
endmodule

// File: tb/tb_axi_split_xform_n.sv
// tb_axi_split_xform_n: scoreboard plus vector-table bench for the N-way split/transform stream block
module tb_axi_split_xform_n;
    localparam int W  = 32;
    localparam int N  = 4;
    localparam int FS = 2;
    typedef struct {
        logic [N-1:0] en;
        logic [N-1:0] inv;
        logic [W-1:0] d;
        logic [N-1:0] vld;
    } vec_t;
    logic              clk;
    logic              reset;
    logic              clear;
    logic [N-1:0]      enable_mask;
    logic [N-1:0]      invert_mask;
    logic [W-1:0]      i_tdata;
    logic              i_tlast;
    logic              i_tvalid;
    logic              i_tready;
    logic [N*W-1:0]    o_tdata;
    logic [N-1:0]      o_tlast;
    logic [N-1:0]      o_tvalid;
    logic [N-1:0]      o_tready;
    logic [N*(FS+1)-1:0] fifo_occupied;
    logic [W:0]        exp_q [N][$];
    int                n_chk = 0;
    int                n_fail = 0;
    int                n_acc = 0;
    int                cyc = 0;
    int                n_rx [N] = '{default: 0};
    logic              m_state = 1'b0;
    logic [N-1:0]      m_en = '0;
    logic [N-1:0]      m_inv = '0;
    bit                bp_done;
    vec_t              vt [7];
    axi_split_xform_n #(.WIDTH(W), .NUM_OUTPUTS(N), .FIFO_SIZE(FS)) dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .enable_mask  (enable_mask),
        .invert_mask  (invert_mask),
        .i_tdata      (i_tdata),
        .i_tlast      (i_tlast),
        .i_tvalid     (i_tvalid),
        .i_tready     (i_tready),
        .o_tdata      (o_tdata),
        .o_tlast      (o_tlast),
        .o_tvalid     (o_tvalid),
        .o_tready     (o_tready),
        .fifo_occupied(fifo_occupied)
    );
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask
    function automatic logic [FS:0] occ(input int k);
        return fifo_occupied[k*(FS+1) +: FS+1];
    endfunction
    // Output monitor: every handshaken beat must match the head of that lane's queue
    always @(negedge clk) begin
        if (!reset && !clear) begin
            for (int k = 0; k < N; k++) begin
                if (o_tvalid[k] && o_tready[k]) begin
                    n_rx[k]++;
                    if (exp_q[k].size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL lane%0d_unexpected: got %0h expected no beat", k, o_tdata[k*W +: W]);
                    end else begin
                        check($sformatf("lane%0d_beat", k), {31'b0, o_tlast[k], o_tdata[k*W +: W]},
                              {31'b0, exp_q[k].pop_front()});
                    end
                end
            end
        end
    end
    task automatic model_push(input logic [W-1:0] d, input logic l);
        logic [N-1:0] en;
        logic [N-1:0] inv;
        en  = m_state ? m_en : enable_mask;
        inv = m_state ? m_inv : invert_mask;
        if (!m_state) begin
            m_en  = enable_mask;
            m_inv = invert_mask;
        end
        for (int k = 0; k < N; k++)
            if (en[k]) exp_q[k].push_back({l, inv[k] ? ~d : d});
        m_state = !l;
    endtask
    // Called at posedge+1; returns at posedge+1 right after the accepting edge
    task automatic send_beat(input logic [W-1:0] d, input logic l);
        int  t;
        bit  done;
        t    = 0;
        done = 0;
        i_tdata  = d;
        i_tlast  = l;
        i_tvalid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (i_tready) begin
                model_push(d, l);
                n_acc++;
                done = 1;
            end else if (++t > 200) begin
                n_chk++;
                n_fail++;
                $display("FAIL send_timeout: got no i_tready expected acceptance of %0h", d);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        i_tvalid = 1'b0;
    endtask
    function automatic bit any_pending();
        for (int k = 0; k < N; k++)
            if (exp_q[k].size() != 0) return 1;
        return 0;
    endfunction
    task automatic drain(input string name);
        int t;
        t = 0;
        while (any_pending() && t < 100) begin
            @(negedge clk);
            t++;
        end
        for (int k = 0; k < N; k++)
            check($sformatf("%s_left%0d", name, k), 64'(exp_q[k].size()), 64'd0);
        @(posedge clk);
        #1;
    endtask
    task automatic flush_model();
        for (int k = 0; k < N; k++) exp_q[k].delete();
        m_state = 1'b0;
    endtask
    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1);
    end
    initial begin
        int b [N];
        int acc0;
        int c0;
        vt[0] = '{4'b0001, 4'b0000, 32'hA5A5_0001, 4'b0001};
        vt[1] = '{4'b0010, 4'b0010, 32'hA5A5_0002, 4'b0010};
        vt[2] = '{4'b0100, 4'b0000, 32'hA5A5_0003, 4'b0100};
        vt[3] = '{4'b1000, 4'b1000, 32'hA5A5_0004, 4'b1000};
        vt[4] = '{4'b1111, 4'b0101, 32'hA5A5_0005, 4'b1111};
        vt[5] = '{4'b0000, 4'b1111, 32'hA5A5_0006, 4'b0000};
        vt[6] = '{4'b0110, 4'b0110, 32'hA5A5_0007, 4'b0110};
        reset = 1'b1;
        clear = 1'b0;
        enable_mask = '0;
        invert_mask = '0;
        i_tdata = '0;
        i_tlast = 1'b0;
        i_tvalid = 1'b0;
        o_tready = '1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_tvalid", 64'(o_tvalid), 64'd0);
        check("rst_occ", 64'(fifo_occupied), 64'd0);
        check("rst_tready", 64'(i_tready), 64'd1);
        @(posedge clk);
        #1;
        enable_mask = 4'hF;
        invert_mask = 4'hA;
        send_beat(32'h1, 1'b0);
        @(negedge clk);
        check("latency_vld", 64'(o_tvalid), 64'hF);
        check("bcast_lane0", 64'(o_tdata[0 +: W]), 64'h1);
        check("bcast_lane1", 64'(o_tdata[W +: W]), 64'hFFFF_FFFE);
        @(posedge clk);
        #1;
        send_beat(32'h2, 1'b0);
        send_beat(32'h3, 1'b0);
        send_beat(32'h4, 1'b1);
        drain("bcast");
        b = n_rx;
        enable_mask = 4'b0011;
        invert_mask = 4'b0000;
        send_beat(32'h10, 1'b0);
        enable_mask = 4'b1100;
        send_beat(32'h11, 1'b0);
        send_beat(32'h12, 1'b0);
        send_beat(32'h13, 1'b0);
        send_beat(32'h14, 1'b1);
        drain("midpkt");
        check("midpkt_rx0", 64'(n_rx[0] - b[0]), 64'd5);
        check("midpkt_rx1", 64'(n_rx[1] - b[1]), 64'd5);
        check("midpkt_rx2", 64'(n_rx[2] - b[2]), 64'd0);
        check("midpkt_rx3", 64'(n_rx[3] - b[3]), 64'd0);
        b = n_rx;
        send_beat(32'h20, 1'b0);
        send_beat(32'h21, 1'b1);
        drain("nextpkt");
        check("nextpkt_rx0", 64'(n_rx[0] - b[0]), 64'd0);
        check("nextpkt_rx2", 64'(n_rx[2] - b[2]), 64'd2);
        check("nextpkt_rx3", 64'(n_rx[3] - b[3]), 64'd2);
        enable_mask = 4'hF;
        invert_mask = 4'h0;
        o_tready = 4'b1101;
        acc0 = n_acc;
        bp_done = 0;
        fork
            begin
                for (int i = 0; i < 10; i++) send_beat(32'h100 + i, i == 9);
                bp_done = 1;
            end
        join_none
        repeat (12) @(negedge clk);
        check("bp_acc", 64'(n_acc - acc0), 64'd4);
        check("bp_tready", 64'(i_tready), 64'd0);
        check("bp_occ1", 64'(occ(1)), 64'd4);
        check("bp_occ0", 64'(occ(0)), 64'd0);
        check("bp_occ2", 64'(occ(2)), 64'd0);
        check("bp_occ3", 64'(occ(3)), 64'd0);
        check("bp_vld", 64'(o_tvalid), 64'b0010);
        @(posedge clk);
        #1;
        o_tready = 4'hF;
        @(negedge clk);
        check("full_pop_tready", 64'(i_tready), 64'd0);
        check("full_pop_occ", 64'(occ(1)), 64'd4);
        check("full_pop_acc", 64'(n_acc - acc0), 64'd4);
        @(negedge clk);
        check("full_pop_after", 64'(occ(1)), 64'd3);
        for (int t = 0; t < 300 && !bp_done; t++) @(negedge clk);
        check("bp_done", 64'(bp_done), 64'd1);
        @(posedge clk);
        #1;
        drain("bp");
        check("bp_total", 64'(n_acc - acc0), 64'd10);
        b = n_rx;
        enable_mask = 4'h0;
        invert_mask = 4'hF;
        c0 = cyc;
        send_beat(32'h30, 1'b0);
        send_beat(32'h31, 1'b0);
        send_beat(32'h32, 1'b1);
        check("dis_cycles", 64'(cyc - c0), 64'd3);
        @(negedge clk);
        check("dis_vld", 64'(o_tvalid), 64'd0);
        @(posedge clk);
        #1;
        enable_mask = 4'b0001;
        invert_mask = 4'b0000;
        send_beat(32'h55, 1'b1);
        drain("dis_idle");
        check("dis_rx0", 64'(n_rx[0] - b[0]), 64'd1);
        check("dis_rx3", 64'(n_rx[3] - b[3]), 64'd0);
        for (int i = 0; i < 7; i++) begin
            enable_mask = vt[i].en;
            invert_mask = vt[i].inv;
            send_beat(vt[i].d, 1'b1);
            @(negedge clk);
            check($sformatf("tbl_vld%0d", i), 64'(o_tvalid), 64'(vt[i].vld));
            @(posedge clk);
            #1;
        end
        drain("tbl");
        for (int i = 0; i < 7; i++) begin
            enable_mask = vt[i].en;
            invert_mask = vt[i].inv;
            send_beat(~vt[i].d, 1'b1);
        end
        drain("b2b");
        for (int r = 0; r < 2; r++) begin
            enable_mask = 4'hF;
            invert_mask = 4'h0;
            o_tready = 4'h0;
            send_beat(32'h200, 1'b0);
            send_beat(32'h201, 1'b0);
            if (r == 0) clear = 1'b1;
            else reset = 1'b1;
            flush_model();
            @(posedge clk);
            #1;
            clear = 1'b0;
            reset = 1'b0;
            @(negedge clk);
            check($sformatf("flush%0d_vld", r), 64'(o_tvalid), 64'd0);
            check($sformatf("flush%0d_occ", r), 64'(fifo_occupied), 64'd0);
            check($sformatf("flush%0d_tready", r), 64'(i_tready), 64'd1);
            @(posedge clk);
            #1;
            o_tready = 4'hF;
            enable_mask = 4'b0101;
            invert_mask = 4'b0100;
            b = n_rx;
            send_beat(32'h300, 1'b0);
            enable_mask = 4'b1010;
            send_beat(32'h301, 1'b1);
            drain($sformatf("flush%0d", r));
            check($sformatf("flush%0d_rx0", r), 64'(n_rx[0] - b[0]), 64'd2);
            check($sformatf("flush%0d_rx1", r), 64'(n_rx[1] - b[1]), 64'd0);
            check($sformatf("flush%0d_rx2", r), 64'(n_rx[2] - b[2]), 64'd2);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
